// File: rtl/cpu_pkg.sv
// Shared types for the multicycle RV32I control path: FSM states, opcodes,
// immediate-select and ALU-operation encodings.
package cpu_pkg;

  localparam int unsigned OP_W       = 7;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned IMM_SRC_W  = 3;

  localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_LUI, S_TRAP
  } state_e;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'd0, ALUOP_SUB = 2'd1, ALUOP_FUNCT = 2'd2
  } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request plus instruction funct fields to an ALU operation;
// flags funct3 encodings the datapath cannot execute.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [1:0]            alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic                  op5_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  illegal_funct_o
);

  always_comb begin
    alu_control_o   = ALU_ADD;
    illegal_funct_o = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type distinguishes SUB; ADDI ignores IR[30].
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM of the multicycle RV32I core: steps the shared datapath
// through fetch/decode/execute/writeback and traps unsupported encodings.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output logic                  mem_req_o,
  output logic                  mem_write_o,
  output logic                  adr_src_o,
  output logic                  ir_write_o,
  output logic                  pc_write_o,
  output logic                  reg_write_o,
  output logic [1:0]            result_src_o,
  output logic [1:0]            alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic [IMM_SRC_W-1:0]  imm_src_o,
  output logic                  illegal_o
);

  state_e                state_q, state_d;
  logic                  illegal_q;
  alu_op_e               alu_op;
  logic [ALU_CTRL_W-1:0] dec_alu_control;
  logic                  illegal_funct;
  imm_src_e              imm_sel;

  alu_decoder u_alu_decoder (
    .alu_op_i        (alu_op),
    .funct3_i        (funct3_i),
    .funct7b5_i      (funct7b5_i),
    .op5_i           (op_i[5]),
    .alu_control_o   (dec_alu_control),
    .illegal_funct_o (illegal_funct)
  );

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    imm_sel = IMM_I;
    case (op_i)
      OP_SW:     imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      OP_LUI:    imm_sel = IMM_U;
      default:   imm_sel = IMM_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_op       = ALUOP_ADD;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o   = 1'b1;
          pc_write_o   = 1'b1;
          alu_src_b_o  = 2'b10;
          result_src_o = 2'b10;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BRANCH:    state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_op      = ALUOP_FUNCT;
        state_d     = illegal_funct ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op      = ALUOP_SUB;
        // funct3[0] inverts the equality test: beq vs bne.
        if (funct3_i[2:1] != 2'b00) begin
          state_d = S_TRAP;
        end else begin
          pc_write_o = zero_i ^ funct3_i[0];
          state_d    = S_FETCH;
        end
      end
      S_JALR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = S_JAL;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b01;
        state_d     = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    alu_control_o = dec_alu_control;
    imm_src_o     = imm_sel;
    // Reset silences every request, enable and select immediately.
    if (!rst_n) begin
      mem_req_o     = 1'b0;
      mem_write_o   = 1'b0;
      adr_src_o     = 1'b0;
      ir_write_o    = 1'b0;
      pc_write_o    = 1'b0;
      reg_write_o   = 1'b0;
      result_src_o  = 2'b00;
      alu_src_a_o   = 2'b00;
      alu_src_b_o   = 2'b00;
      alu_control_o = '0;
      imm_src_o     = '0;
    end
  end

  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// legal instruction streams against a per-instruction summary model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_write_o(mem_write),
    .adr_src_o(adr_src), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .reg_write_o(reg_write), .result_src_o(result_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_control_o(alu_control), .imm_src_o(imm_src),
    .illegal_o(illegal)
  );

  // Expected whole-instruction behaviour, derived from the ISA-level rules.
  typedef struct {
    int         cycles;
    int         regw;
    int         pcw;
    int         memw;
    bit         mem;
    logic [2:0] imm;
    logic [3:0] wb_alu;
    logic [1:0] wb_a;
    logic [1:0] wb_rsrc;
  } model_t;

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic rtype, input logic f7);
    case (f3)
      3'd0:    return (rtype && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd4:    return 4'd4;
      3'd5:    return 4'd7;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  function automatic model_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z);
    model_t m;
    m.cycles = 4; m.regw = 1; m.pcw = 1; m.memw = 0; m.mem = 1'b0;
    m.imm = 3'd0; m.wb_alu = 4'd0; m.wb_a = 2'b00; m.wb_rsrc = 2'b00;
    case (o)
      7'b0000011: begin m.cycles = 5; m.wb_rsrc = 2'b01; m.mem = 1'b1; end
      7'b0100011: begin m.regw = 0; m.memw = 1; m.imm = 3'd1; m.mem = 1'b1; end
      7'b0110011: begin m.wb_alu = ref_alu(f3, 1'b1, f7); m.wb_a = 2'b10; end
      7'b0010011: begin m.wb_alu = ref_alu(f3, 1'b0, f7); m.wb_a = 2'b10; end
      7'b1100011: begin m.cycles = 3; m.regw = 0; m.imm = 3'd2; m.pcw = 1 + int'(z ^ f3[0]); end
      7'b1101111: begin m.imm = 3'd3; m.pcw = 2; m.wb_a = 2'b01; end
      7'b1100111: begin m.cycles = 5; m.pcw = 2; m.wb_a = 2'b01; end
      7'b0110111: begin m.imm = 3'd4; m.wb_a = 2'b11; end
      default: ;
    endcase
    return m;
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one legal instruction from its FETCH cycle up to the next FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm, input string name);
    model_t     m;
    int         cyc = 0, rw = 0, pw = 0, iw = 0, mw = 0, bad = 0, imm_bad = 0, wl, exp_cyc;
    bit         fetched = 1'b0;
    logic [3:0] prev_alu = 4'd0, wb_alu = 4'd0;
    logic [1:0] prev_a = 2'b00, wb_a = 2'b00, wb_rsrc = 2'b00;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    m = model(o, f3, f7, z);
    exp_cyc = m.cycles + wf + (m.mem ? wm : 0);
    wl = wf;
    forever begin
      #1;
      if (fetched && mem_req && !adr_src) break;
      if (cyc >= 60) break;
      if (mem_req) begin
        if (wl > 0) begin mem_ready = 1'b0; wl--; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (reg_write) begin rw++; wb_alu = prev_alu; wb_a = prev_a; wb_rsrc = result_src; end
      if (pc_write) pw++;
      if (ir_write) iw++;
      if (mem_write) mw++;
      if ((ir_write || pc_write) && mem_req && !mem_ready) bad++;
      if (ir_write && (!mem_req || adr_src)) bad++;
      if (mem_write && !(mem_req && adr_src)) bad++;
      if (imm_src !== m.imm) imm_bad++;
      if (mem_req && mem_ready) begin
        if (!adr_src) fetched = 1'b1;
        wl = wm;
      end
      prev_alu = alu_control;
      prev_a   = alu_src_a;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== exp_cyc) begin
      failures++;
      $display("FAIL %s cycles: got %0d want %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (rw !== m.regw || pw !== m.pcw || iw !== 1 || mw !== (m.memw != 0 ? 1 + wm : 0)) begin
      failures++;
      $display("FAIL %s enables: reg_write %0d/%0d pc_write %0d/%0d ir_write %0d/1 mem_write %0d",
               name, rw, m.regw, pw, m.pcw, iw, mw);
    end
    checks++;
    if (bad !== 0 || imm_bad !== 0) begin
      failures++;
      $display("FAIL %s handshake/imm_src: stall errors %0d imm_src errors %0d (want imm %0d)",
               name, bad, imm_bad, m.imm);
    end
    if (m.regw != 0) begin
      checks++;
      if (wb_alu !== m.wb_alu || wb_a !== m.wb_a || wb_rsrc !== m.wb_rsrc) begin
        failures++;
        $display("FAIL %s execute: alu_control %b/%b alu_src_a %b/%b result_src %b/%b",
                 name, wb_alu, m.wb_alu, wb_a, m.wb_a, wb_rsrc, m.wb_rsrc);
      end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    op = 7'b0110111; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    rst_n = 1'b0; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
         alu_src_a, alu_src_b, alu_control, imm_src} !== 19'd0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: mem_req=%b ir_write=%b imm_src=%0d illegal=%b want all 0",
               mem_req, ir_write, imm_src, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1; op = 7'b0000011; mem_ready = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b1 || adr_src !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: mem_req=%b adr_src=%b illegal=%b want 1 0 0",
               mem_req, adr_src, illegal);
    end
    repeat (3) @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b1 || adr_src !== 1'b1) begin
      failures++;
      $display("FAIL memread_reach: mem_req=%b adr_src=%b want 1 1", mem_req, adr_src);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'($urandom_range(0, 1)); #1;
      if (mem_req | mem_write | ir_write | pc_write | reg_write | adr_src) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_mid_lw: %0d cycles with activity want 0", bad);
    end
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    checks++;
    if (mem_req !== 1'b1 || adr_src !== 1'b0 || illegal !== 1'b0 || ir_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_lw_release: mem_req=%b adr_src=%b illegal=%b ir_write=%b want 1 0 0 0",
               mem_req, adr_src, illegal, ir_write);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 2, "lw_wait2");
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b1, 0, 0, "lw_nowait");
  endtask

  task automatic test_sw_branch();
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, "sw");
    run_instr(7'b0100011, 3'b010, 1'b1, 1'b1, 1, 3, "sw_wait");
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, "beq_taken");
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, "bne_not_taken");
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1, 0, "beq_not_taken");
    run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, "bne_taken");
  endtask

  task automatic test_jumps();
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, "jal");
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, "jalr");
    run_instr(7'b0110111, 3'b101, 1'b1, 1'b0, 0, 0, "lui");
  endtask

  task automatic test_sub_addi();
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, "r_sub");
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, "i_addi");
    run_instr(7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0, "r_srl_f7");
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    logic [6:0] o;
    logic [2:0] f3;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    for (int n = 0; n < 40; n++) begin
      o  = ops[$urandom_range(0, 7)];
      f3 = 3'($urandom_range(0, 7));
      if (o == 7'b1100011) f3 = 3'($urandom_range(0, 1));
      else if (f3 == 3'd3 && (o == 7'b0110011 || o == 7'b0010011)) f3 = 3'd7;
      run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", n));
    end
  endtask

  task automatic trap_case(input logic [6:0] o, input logic [2:0] f3, input int lat,
                           input string name);
    int k = -1;
    int bad = 0;
    do_reset(2);
    op = o; funct3 = f3; funct7b5 = 1'b0; zero = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = 1'b1; #1;
      if (illegal) begin k = c; break; end
      @(negedge clk);
    end
    checks++;
    if (k !== lat) begin
      failures++;
      $display("FAIL %s trap_latency: illegal at cycle %0d want %0d", name, k, lat);
    end
    for (int c = 0; c < 10; c++) begin
      mem_ready = 1'($urandom_range(0, 1)); #1;
      if (mem_req | mem_write | ir_write | pc_write | reg_write | (illegal !== 1'b1)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s trap_hold: %0d bad cycles want 0", name, bad);
    end
    do_reset(1);
    mem_ready = 1'b0; #1;
    checks++;
    if (illegal !== 1'b0 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL %s trap_clear: illegal=%b mem_req=%b want 0 1", name, illegal, mem_req);
    end
  endtask

  task automatic test_illegal();
    trap_case(7'b1110011, 3'b000, 2, "bad_opcode");
    trap_case(7'b0110011, 3'b011, 3, "r_funct3_011");
    trap_case(7'b1100011, 3'b100, 3, "branch_funct3_100");
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_sw_branch();
    test_jumps();
    test_sub_addi();
    test_random();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
